// File: rtl/game_ctrl.sv
// game_ctrl - page and turn sequencing for the two-player finger-sum game.
//
// Acts on rising key edges, only on cycles where tick=1. It owns the page
// state, the board digits, the cursor/selection handshake and win/draw
// detection. Every output is registered so it can drive the page mux and
// the renderers directly.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active low
//   tick          one-cycle sampling strobe
//   keys[4:0]     key levels: [0] up, [1] left, [2] right, [3] down, [4] space
//   page_status   0 main, 1 help, 2 config, 3 game
//   total_number  hands per player N (2..5)
//   status        ten BCD digits: row 0 at offsets 0..16, row 1 at 20..36
//   cur_player    player to move
//   selecting     first hand chosen, waiting for the second
//   cur_select    cursor bit offset
//   selected      first-chosen bit offset
//   predict       (digit at cursor + digit at selection) mod 10, one cycle late
//   game_end      0 running, 1 player 0 wins, 2 player 1 wins, 3 draw
//
// Page states:
//   PG_MAIN   | title page; up -> config, down -> help
//   PG_HELP   | help text; down -> main
//   PG_CONFIG | choose N with left/right; up starts a game, down -> main
//   PG_GAME   | board play; after game over only down (-> main) is honoured

module game_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [4:0]  keys,
  output logic [1:0]  page_status,
  output logic [2:0]  total_number,
  output logic [39:0] status,
  output logic        cur_player,
  output logic        selecting,
  output logic [5:0]  cur_select,
  output logic [5:0]  selected,
  output logic [3:0]  predict,
  output logic [1:0]  game_end
);

  localparam logic [39:0] BOARD_INIT = 40'h1111111111;

  typedef enum logic [1:0] {
    PG_MAIN   = 2'd0,
    PG_HELP   = 2'd1,
    PG_CONFIG = 2'd2,
    PG_GAME   = 2'd3
  } page_t;

  page_t      page;
  logic [4:0] prev_keys;
  logic [4:0] key_ev;
  logic [4:0] act;
  logic [2:0] zero_cnt0;
  logic [2:0] zero_cnt1;
  logic [1:0] add_zero;

  assign page_status = page;

  // Keep only the lowest set bit of the edge vector: bit 0 (up) wins.
  assign key_ev = keys & ~prev_keys;
  assign act    = key_ev & (~key_ev + 5'd1);

  // Cursor arithmetic
  logic [5:0] last_off;
  logic [5:0] cur_vert;
  logic [5:0] cur_left;
  logic [5:0] cur_right;
  logic       cur_row;
  logic       sel_row;

  assign last_off = {1'b0, total_number - 3'd1, 2'b00};
  assign cur_row  = (cur_select >= 6'd20);
  assign sel_row  = (selected >= 6'd20);

  always_comb begin
    cur_vert = cur_row ? cur_select - 6'd20 : cur_select + 6'd20;
    if (cur_select == 6'd0)
      cur_left = last_off;
    else if (cur_select == 6'd20)
      cur_left = 6'd20 + last_off;
    else
      cur_left = cur_select - 6'd4;
    if (cur_select == last_off)
      cur_right = 6'd0;
    else if (cur_select == 6'd20 + last_off)
      cur_right = 6'd20;
    else
      cur_right = cur_select + 6'd4;
  end

  // Move evaluation: the target is whichever hand sits in the mover's row.
  logic [5:0]  tgt_off;
  logic [5:0]  src_off;
  logic [3:0]  tgt_dig;
  logic [3:0]  src_dig;
  logic [4:0]  dig_sum;
  logic [3:0]  new_dig;
  logic [39:0] status_nxt;
  logic [1:0]  add_zero_nxt;
  logic [2:0]  mover_cnt_nxt;
  logic [4:0]  pred_sum;
  logic [3:0]  pred_nxt;

  assign tgt_off = (cur_row == cur_player) ? cur_select : selected;
  assign src_off = (cur_row == cur_player) ? selected : cur_select;
  assign tgt_dig = status[tgt_off +: 4];
  assign src_dig = status[src_off +: 4];
  assign dig_sum = {1'b0, tgt_dig} + {1'b0, src_dig};
  // Sums 10..18 wrap correctly in 4 bits after subtracting 10.
  assign new_dig = (dig_sum >= 5'd10) ? dig_sum[3:0] - 4'd10 : dig_sum[3:0];

  assign add_zero_nxt  = {add_zero[0], src_dig == 4'd0};
  assign mover_cnt_nxt = (cur_player ? zero_cnt1 : zero_cnt0) + {2'b00, new_dig == 4'd0};

  always_comb begin
    status_nxt = status;
    status_nxt[tgt_off +: 4] = new_dig;
  end

  assign pred_sum = {1'b0, status[cur_select +: 4]} + {1'b0, status[selected +: 4]};
  assign pred_nxt = (pred_sum >= 5'd10) ? pred_sum[3:0] - 4'd10 : pred_sum[3:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      page         <= PG_MAIN;
      total_number <= 3'd2;
      status       <= BOARD_INIT;
      cur_player   <= 1'b0;
      selecting    <= 1'b0;
      cur_select   <= 6'd0;
      selected     <= 6'd0;
      game_end     <= 2'd0;
      zero_cnt0    <= 3'd0;
      zero_cnt1    <= 3'd0;
      add_zero     <= 2'b00;
      prev_keys    <= 5'b00000;
      predict      <= 4'd2;
    end else begin
      predict <= pred_nxt;
      if (tick) begin
        prev_keys <= keys;
        case (page)
          PG_MAIN: begin
            if (act[0])      page <= PG_CONFIG;
            else if (act[3]) page <= PG_HELP;
          end
          PG_HELP: begin
            if (act[3]) page <= PG_MAIN;
          end
          PG_CONFIG: begin
            if (act[0]) begin
              page       <= PG_GAME;
              status     <= BOARD_INIT;
              cur_player <= 1'b0;
              selecting  <= 1'b0;
              cur_select <= 6'd0;
              selected   <= 6'd0;
              game_end   <= 2'd0;
              zero_cnt0  <= 3'd0;
              zero_cnt1  <= 3'd0;
              add_zero   <= 2'b00;
            end else if (act[1]) begin
              if (total_number > 3'd2) total_number <= total_number - 3'd1;
            end else if (act[2]) begin
              if (total_number < 3'd5) total_number <= total_number + 3'd1;
            end else if (act[3]) begin
              page <= PG_MAIN;
            end
          end
          PG_GAME: begin
            if (game_end != 2'd0) begin
              if (act[3]) page <= PG_MAIN;
            end else if (act[0] || act[3]) begin
              cur_select <= cur_vert;
            end else if (act[1]) begin
              cur_select <= cur_left;
            end else if (act[2]) begin
              cur_select <= cur_right;
            end else if (act[4]) begin
              if (!selecting) begin
                selected  <= cur_select;
                selecting <= 1'b1;
              end else if ((cur_row == sel_row) || (tgt_dig == 4'd0)) begin
                selecting <= 1'b0;
              end else begin
                status   <= status_nxt;
                add_zero <= add_zero_nxt;
                if (cur_player) zero_cnt1 <= mover_cnt_nxt;
                else            zero_cnt0 <= mover_cnt_nxt;
                if (mover_cnt_nxt == total_number)
                  game_end <= cur_player ? 2'd2 : 2'd1;
                else if (add_zero_nxt == 2'b11)
                  game_end <= 2'd3;
                cur_player <= ~cur_player;
                cur_select <= tgt_off;
                selected   <= src_off;
                selecting  <= 1'b0;
              end
            end
          end
          default: page <= PG_MAIN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed game scenarios plus random key traffic, all
// compared every cycle against a row/column board model.

module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [4:0]  keys;
  logic [1:0]  page_status;
  logic [2:0]  total_number;
  logic [39:0] status;
  logic        cur_player;
  logic        selecting;
  logic [5:0]  cur_select;
  logic [5:0]  selected;
  logic [3:0]  predict;
  logic [1:0]  game_end;

  localparam logic [4:0] K_UP    = 5'b00001;
  localparam logic [4:0] K_LEFT  = 5'b00010;
  localparam logic [4:0] K_RIGHT = 5'b00100;
  localparam logic [4:0] K_DOWN  = 5'b01000;
  localparam logic [4:0] K_SPACE = 5'b10000;

  always #5 clk = ~clk;

  game_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .keys        (keys),
    .page_status (page_status),
    .total_number(total_number),
    .status      (status),
    .cur_player  (cur_player),
    .selecting   (selecting),
    .cur_select  (cur_select),
    .selected    (selected),
    .predict     (predict),
    .game_end    (game_end)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: board as digits indexed [player][hand], cursor as row/col.
  int         m_page, m_n, m_pl, m_sel, m_end;
  int         m_cr, m_cc, m_sr, m_sc;
  int         m_dig [2][5];
  int         m_zc  [2];
  int         m_az_old, m_az_new;
  logic [4:0] m_prev;

  task automatic m_fresh();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 5; i++) m_dig[p][i] = 1;
    m_cr = 0; m_cc = 0; m_sr = 0; m_sc = 0;
    m_pl = 0; m_sel = 0; m_end = 0;
    m_zc[0] = 0; m_zc[1] = 0;
    m_az_old = 0; m_az_new = 0;
  endtask

  task automatic m_reset();
    m_page = 0; m_n = 2; m_prev = 5'b0;
    m_fresh();
  endtask

  task automatic m_space();
    int tr, tc, sr2, sc2;
    if (m_sel == 0) begin
      m_sr = m_cr; m_sc = m_cc; m_sel = 1;
    end else if (m_sr == m_cr) begin
      m_sel = 0;
    end else begin
      if (m_cr == m_pl) begin tr = m_cr; tc = m_cc; sr2 = m_sr; sc2 = m_sc; end
      else              begin tr = m_sr; tc = m_sc; sr2 = m_cr; sc2 = m_cc; end
      if (m_dig[tr][tc] == 0) begin
        m_sel = 0;
      end else begin
        m_dig[tr][tc] = (m_dig[tr][tc] + m_dig[sr2][sc2]) % 10;
        m_az_old = m_az_new;
        m_az_new = (m_dig[sr2][sc2] == 0) ? 1 : 0;
        if (m_dig[tr][tc] == 0) m_zc[m_pl] = (m_zc[m_pl] + 1) % 8;
        if (m_zc[m_pl] == m_n) m_end = m_pl + 1;
        else if (m_az_old == 1 && m_az_new == 1) m_end = 3;
        m_cr = tr; m_cc = tc; m_sr = sr2; m_sc = sc2;
        m_pl = 1 - m_pl; m_sel = 0;
      end
    end
  endtask

  task automatic m_step(input logic [4:0] k);
    logic [4:0] ev;
    int e;
    ev = k & ~m_prev;
    m_prev = k;
    e = -1;
    for (int i = 4; i >= 0; i--) if (ev[i]) e = i;
    if (e < 0) return;
    case (m_page)
      0: if (e == 0) m_page = 2; else if (e == 3) m_page = 1;
      1: if (e == 3) m_page = 0;
      2: case (e)
           0: begin m_page = 3; m_fresh(); end
           1: if (m_n > 2) m_n = m_n - 1;
           2: if (m_n < 5) m_n = m_n + 1;
           3: m_page = 0;
           default: ;
         endcase
      default: begin
        if (m_end != 0) begin
          if (e == 3) m_page = 0;
        end else case (e)
          0, 3: m_cr = 1 - m_cr;
          1: m_cc = (m_cc == 0) ? m_n - 1 : m_cc - 1;
          2: m_cc = (m_cc == m_n - 1) ? 0 : m_cc + 1;
          default: m_space();
        endcase
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input int ep);
    logic [39:0] st;
    st = '0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 5; i++) st[p*20 + i*4 +: 4] = 4'(m_dig[p][i]);
    chk("page_status", 40'(page_status), 40'(m_page));
    chk("total_number", 40'(total_number), 40'(m_n));
    chk("status", status, st);
    chk("cur_player", 40'(cur_player), 40'(m_pl));
    chk("selecting", 40'(selecting), 40'(m_sel));
    chk("cur_select", 40'(cur_select), 40'(m_cr*20 + m_cc*4));
    chk("selected", 40'(selected), 40'(m_sr*20 + m_sc*4));
    chk("predict", 40'(predict), 40'(ep));
    chk("game_end", 40'(game_end), 40'(m_end));
  endtask

  // One clock: predict lags, so its expectation comes from the pre-edge model.
  task automatic cycle(input logic [4:0] k, input logic t);
    int ep;
    ep = (m_dig[m_cr][m_cc] + m_dig[m_sr][m_sc]) % 10;
    keys = k; tick = t;
    @(posedge clk);
    if (t) m_step(k);
    #1;
    check_all(ep);
  endtask

  task automatic do_reset();
    rst = 1'b0; keys = 5'b0; tick = 1'b1;
    @(posedge clk);
    m_reset();
    #1;
    check_all(2);
    rst = 1'b1;
  endtask

  task automatic press(input logic [4:0] k);
    cycle(k, 1'b1);
    cycle(5'b0, 1'b1);
  endtask

  task automatic goto_hand(input int r, input int c);
    for (int g = 0; g < 4 && m_cr != r; g++) press(K_UP);
    for (int g = 0; g < 6 && m_cc != c; g++) press(K_RIGHT);
  endtask

  task automatic mv(input int r1, input int c1, input int r2, input int c2);
    goto_hand(r1, c1); press(K_SPACE);
    goto_hand(r2, c2); press(K_SPACE);
  endtask

  // N=2: player 0 counts hand 0 up by ones to zero while player 1 does the
  // same on its hand 0; leaves a=(0,1), b=(0,1), one zero each, player 0 next.
  task automatic phase_zero_hands();
    for (int i = 0; i < 9; i++) begin
      mv(1, 1, 0, 0);
      mv(0, 1, 1, 0);
    end
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; keys = 5'b0;
    m_reset();
    do_reset();
    chk("reset_page", 40'(page_status), 40'd0);
    chk("reset_n", 40'(total_number), 40'd2);
    chk("reset_board", status, 40'h1111111111);

    // Navigation and N saturation
    press(K_UP);
    chk("nav_config", 40'(page_status), 40'd2);
    repeat (4) press(K_RIGHT);
    chk("n_max", 40'(total_number), 40'd5);
    repeat (5) press(K_LEFT);
    chk("n_min", 40'(total_number), 40'd2);
    press(K_DOWN);
    chk("nav_main", 40'(page_status), 40'd0);
    press(K_DOWN);
    chk("nav_help", 40'(page_status), 40'd1);
    press(K_DOWN);
    chk("nav_back", 40'(page_status), 40'd0);

    // Held key counts once; then N=3 cursor wrap
    press(K_UP);
    press(K_RIGHT);
    repeat (3) cycle(K_RIGHT, 1'b1);
    cycle(5'b0, 1'b1);
    chk("held_key", 40'(total_number), 40'd4);
    press(K_LEFT);
    press(K_UP);
    chk("game_page", 40'(page_status), 40'd3);
    press(K_LEFT);  chk("wrap_left0", 40'(cur_select), 40'd8);
    press(K_RIGHT); chk("wrap_right0", 40'(cur_select), 40'd0);
    press(K_DOWN);  chk("row_down", 40'(cur_select), 40'd20);
    press(K_LEFT);  chk("wrap_left1", 40'(cur_select), 40'd28);
    press(K_UP);    chk("row_up", 40'(cur_select), 40'd8);

    // Legal move, same-row cancel, priority, tick gating
    mv(0, 0, 1, 0);
    chk("move_digit", 40'(status[3:0]), 40'd2);
    chk("move_player", 40'(cur_player), 40'd1);
    mv(0, 0, 0, 1);
    chk("cancel_sel", 40'(selecting), 40'd0);
    chk("cancel_board", 40'(status[7:0]), 40'h12);
    cycle(K_UP | K_SPACE, 1'b1);
    chk("prio_sel", 40'(selecting), 40'd0);
    chk("prio_cursor", 40'(cur_select), 40'd24);
    cycle(5'b0, 1'b1);
    cycle(K_DOWN, 1'b0);
    chk("no_tick", 40'(cur_select), 40'd24);
    cycle(5'b0, 1'b1);

    // Reset with a half-made selection
    press(K_SPACE);
    do_reset();
    chk("rst_mid_sel", 40'(selecting), 40'd0);
    chk("rst_mid_board", status, 40'h1111111111);

    // Win for player 0 at N=2
    press(K_UP); press(K_UP);
    phase_zero_hands();
    for (int j = 0; j < 9; j++) begin
      mv(1, 1, 0, 1);
      if (j < 8) mv(0, 0, 1, 1);
    end
    chk("win_p0", 40'(game_end), 40'd1);
    press(K_SPACE);
    chk("end_ignores_space", 40'(selecting), 40'd0);
    press(K_DOWN);
    chk("end_to_main", 40'(page_status), 40'd0);

    // Rejected move onto a zero hand, then draw by two zero sources
    press(K_UP); press(K_UP);
    phase_zero_hands();
    mv(1, 1, 0, 0);
    chk("reject_player", 40'(cur_player), 40'd0);
    mv(1, 0, 0, 1);
    mv(0, 0, 1, 1);
    chk("draw", 40'(game_end), 40'd3);

    // Random key traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] k;
      if ($urandom_range(0, 1) == 1) k = 5'(1 << $urandom_range(0, 4));
      else if ($urandom_range(0, 2) == 0) k = 5'($urandom_range(0, 31));
      else k = 5'b0;
      cycle(k, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
